// File: rtl/gray_conv_arbiter.sv
// Round-robin arbitrated gray/binary converter: one shared conversion datapath,
// num_req requesters in, one tagged result out.
module gray_conv_arbiter #(
    parameter int data_width = 4,
    parameter int num_req    = 4,
    parameter int id_width   = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [num_req-1:0]             req_valid,
    input  logic [num_req-1:0]             req_mode,
    input  logic [num_req*data_width-1:0]  req_data,
    output logic [num_req-1:0]             req_ready,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic [data_width-1:0]          resp_data,
    output logic [id_width-1:0]            resp_id,
    output logic                           resp_mode,
    output logic                           busy,
    output logic [1:0]                     fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state, state_next;
    logic [id_width-1:0]   rr_ptr;
    logic [id_width-1:0]   winner;
    logic                  found;
    logic                  accept;
    logic [data_width-1:0] op_data;
    logic                  op_mode;
    logic [id_width-1:0]   op_id;
    logic [data_width-1:0] conv_result;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid side holds its payload until then, ready never waits on valid's partner.
    always_comb begin : rr_search
        int                  idx;
        logic [id_width-1:0] idx_v;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        idx_v  = '0;
        for (int i = 0; i < num_req; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= num_req) idx = idx - num_req;
            idx_v = id_width'(idx);
            if (!found && req_valid[idx_v]) begin
                found  = 1'b1;
                winner = idx_v;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && state == IDLE && found) req_ready[winner] = 1'b1;
    end

    assign accept    = |(req_valid & req_ready);
    assign busy      = (state != IDLE);
    assign fsm_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = CONV;
            CONV:    state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Shared converter; gray->binary is a running XOR from the MSB down.
    always_comb begin
        conv_result = '0;
        if (op_mode) begin
            conv_result = op_data ^ (op_data >> 1);
        end else begin
            conv_result[data_width-1] = op_data[data_width-1];
            for (int i = data_width - 2; i >= 0; i--)
                conv_result[i] = conv_result[i+1] ^ op_data[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            op_data    <= '0;
            op_mode    <= 1'b0;
            op_id      <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_id    <= '0;
            resp_mode  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_data <= req_data[winner*data_width +: data_width];
                        op_mode <= req_mode[winner];
                        op_id   <= winner;
                        rr_ptr  <= (winner == id_width'(num_req - 1)) ? '0 : winner + 1'b1;
                    end
                end
                CONV: begin
                    resp_data  <= conv_result;
                    resp_id    <= op_id;
                    resp_mode  <= op_mode;
                    resp_valid <= 1'b1;
                end
                RESP: begin
                    if (resp_ready) resp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Bench for gray_conv_arbiter: directed vector table, multi-cycle corner
// sequences and randomized traffic checked against a spec-level model.
module tb_gray_conv_arbiter;

    localparam int W  = 4;
    localparam int N  = 4;
    localparam int IW = 2;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_mode;
    logic [N*W-1:0]  req_data;
    logic [N-1:0]    req_ready;
    logic            resp_valid;
    logic            resp_ready;
    logic [W-1:0]    resp_data;
    logic [IW-1:0]   resp_id;
    logic            resp_mode;
    logic            busy;
    logic [1:0]      fsm_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q[$];
    int           exp_id_q[$];
    logic         exp_mode_q[$];

    typedef struct {
        int           idx;
        logic         mode;
        logic [W-1:0] data;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[6];

    gray_conv_arbiter #(.data_width(W), .num_req(N), .id_width(IW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_mode   (req_mode),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .resp_mode  (resp_mode),
        .busy       (busy),
        .fsm_state  (fsm_state)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard helpers
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] model_conv(input logic mode, input logic [W-1:0] d);
        logic [W-1:0] r;
        r = '0;
        if (mode) r = d ^ (d >> 1);
        else for (int s = 0; s < W; s++) r = r ^ (d >> s);
        return r;
    endfunction

    // driver tasks
    task automatic apply_req(input int idx, input logic mode, input logic [W-1:0] data);
        req_valid[idx]       = 1'b1;
        req_mode[idx]        = mode;
        req_data[idx*W +: W] = data;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        resp_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Starts at a negedge with the FSM idle; ends idle at a negedge.
    task automatic single_txn(input int idx, input logic mode, input logic [W-1:0] data,
                              input logic [W-1:0] exp, input string name);
        apply_req(idx, mode, data);
        #1;
        check({name, "_ready"}, req_ready, 32'(1 << idx));
        check({name, "_idle_busy"}, busy, 0);
        @(negedge clk);
        req_valid = '0;
        check({name, "_conv_busy"}, busy, 1);
        check({name, "_conv_valid"}, resp_valid, 0);
        check({name, "_conv_ready"}, req_ready, 0);
        @(negedge clk);
        check({name, "_valid"}, resp_valid, 1);
        check({name, "_data"}, resp_data, exp);
        check({name, "_id"}, resp_id, idx);
        check({name, "_mode"}, resp_mode, mode);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check({name, "_done_valid"}, resp_valid, 0);
        check({name, "_done_busy"}, busy, 0);
        check({name, "_hold_data"}, resp_data, exp);
    endtask

    initial begin
        logic [W-1:0] held_data;
        int           grant_id[6];
        int           grant_cyc[6];
        int           n_grant;
        logic [N-1:0] pend;
        logic         m_mode[N];
        logic [W-1:0] m_data[N];
        int           m_ptr;
        int           w;

        vecs[0] = '{idx: 2, mode: 1'b0, data: 4'b1101, exp: 4'b1001};
        vecs[1] = '{idx: 1, mode: 1'b1, data: 4'b1001, exp: 4'b1101};
        vecs[2] = '{idx: 1, mode: 1'b1, data: 4'b1111, exp: 4'b1000};
        vecs[3] = '{idx: 3, mode: 1'b0, data: 4'b1111, exp: 4'b1010};
        vecs[4] = '{idx: 0, mode: 1'b0, data: 4'b0000, exp: 4'b0000};
        vecs[5] = '{idx: 3, mode: 1'b1, data: 4'b0110, exp: 4'b0101};

        // reset with every requester asserting
        rst_n      = 1'b0;
        req_valid  = '1;
        req_mode   = '0;
        req_data   = '0;
        resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_resp_id", resp_id, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        #1;
        check("rst_first_grant", req_ready, 4'b0001);
        @(negedge clk);
        req_valid = '0;
        check("rst_first_busy", busy, 1);
        @(negedge clk);
        check("rst_first_valid", resp_valid, 1);
        check("rst_first_id", resp_id, 0);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;

        // directed conversion vectors
        foreach (vecs[i])
            single_txn(vecs[i].idx, vecs[i].mode, vecs[i].data, vecs[i].exp, $sformatf("vec%0d", i));

        // backpressure: response held 5 extra cycles while requester 0 waits
        apply_req(2, 1'b0, 4'b1101);
        #1;
        check("bp_grant", req_ready, 4'b0100);
        @(negedge clk);
        req_valid = 4'b0001;
        check("bp_conv_ready", req_ready, 0);
        @(negedge clk);
        check("bp_valid", resp_valid, 1);
        check("bp_data", resp_data, 4'b1001);
        check("bp_id", resp_id, 2);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("bp_hold_valid%0d", c), resp_valid, 1);
            check($sformatf("bp_hold_data%0d", c), resp_data, 4'b1001);
            check($sformatf("bp_hold_id%0d", c), resp_id, 2);
            check($sformatf("bp_hold_ready%0d", c), req_ready, 0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("bp_after_busy", busy, 0);
        check("bp_after_valid", resp_valid, 0);
        check("bp_next_grant", req_ready, 4'b0001);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        check("bp_req0_id", resp_id, 0);
        check("bp_req0_data", resp_data, 4'b0000);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;

        // reset while in CONV
        apply_req(2, 1'b1, 4'b0110);
        #1;
        check("rc_grant", req_ready, 4'b0100);
        @(negedge clk);
        req_valid = '0;
        check("rc_conv_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rc_busy_drop", busy, 0);
        check("rc_valid_drop", resp_valid, 0);
        req_valid = '1;
        #1;
        check("rc_ready_in_reset", req_ready, 0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("rc_no_stale%0d", c), resp_valid, 0);
        end

        // fairness from a fresh pointer: all requesters continuously valid
        req_valid  = '1;
        resp_ready = 1'b1;
        n_grant    = 0;
        #1;
        for (int cyc = 0; cyc < 40 && n_grant < 6; cyc++) begin
            if (req_ready != '0) begin
                grant_cyc[n_grant] = cyc;
                grant_id[n_grant]  = $clog2(int'(req_ready));
                n_grant++;
            end
            if (n_grant < 6) begin
                @(negedge clk);
                #1;
            end
        end
        check("fair_grant_count", n_grant, 6);
        for (int g = 0; g < n_grant; g++) begin
            check($sformatf("fair_order%0d", g), grant_id[g], g % N);
            if (g > 0)
                check($sformatf("fair_spacing%0d", g), grant_cyc[g] - grant_cyc[g-1], 3);
        end
        @(negedge clk);
        req_valid = '0;
        repeat (3) @(negedge clk);
        resp_ready = 1'b0;

        // randomized traffic against the reference model
        pulse_reset();
        pend  = '0;
        m_ptr = 0;
        for (int j = 0; j < N; j++) begin
            m_mode[j] = 1'b0;
            m_data[j] = '0;
        end
        for (int t = 0; t < 40; t++) begin
            for (int j = 0; j < N; j++) begin
                if (!pend[j] && $urandom_range(0, 1) == 1) begin
                    pend[j]   = 1'b1;
                    m_mode[j] = 1'($urandom_range(0, 1));
                    m_data[j] = W'($urandom_range(0, (1 << W) - 1));
                    apply_req(j, m_mode[j], m_data[j]);
                end
            end
            if (pend == '0) begin
                w         = $urandom_range(0, N - 1);
                pend[w]   = 1'b1;
                m_mode[w] = 1'($urandom_range(0, 1));
                m_data[w] = W'($urandom_range(0, (1 << W) - 1));
                apply_req(w, m_mode[w], m_data[w]);
            end
            #1;
            w = -1;
            for (int k = 0; k < N; k++)
                if (w < 0 && pend[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            check($sformatf("rand_grant%0d", t), req_ready, 32'(1 << w));
            exp_q.push_back(model_conv(m_mode[w], m_data[w]));
            exp_id_q.push_back(w);
            exp_mode_q.push_back(m_mode[w]);
            pend[w] = 1'b0;
            m_ptr   = (w + 1) % N;
            @(negedge clk);
            req_valid[w] = 1'b0;
            @(negedge clk);
            repeat ($urandom_range(0, 3)) begin
                check($sformatf("rand_wait_valid%0d", t), resp_valid, 1);
                @(negedge clk);
            end
            held_data = exp_q.pop_front();
            check($sformatf("rand_valid%0d", t), resp_valid, 1);
            check($sformatf("rand_data%0d", t), resp_data, held_data);
            check($sformatf("rand_id%0d", t), resp_id, exp_id_q.pop_front());
            check($sformatf("rand_mode%0d", t), resp_mode, exp_mode_q.pop_front());
            resp_ready = 1'b1;
            @(negedge clk);
            resp_ready = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
